// File: rtl/hw_malloc_mc.sv
// hw_malloc_mc: multi-channel cell allocator.
// Round-robin arbitration over NUM_CH ingress channels, one cell per cycle.
// Each accepted header reserves its whole packet length up front, so a body
// cell always finds a free address. The free list is an init address
// generator followed by a FIFO of recycled addresses.
// Optional build macro HW_MALLOC_STATS_EN adds saturating allocation/drop
// counters on o_stat_alloc / o_stat_drop.
`timescale 1ns/1ps

module hw_malloc_mc #(
  parameter int NUM_CH      = 2,
  parameter int MWIDTH      = 4,
  parameter int AWIDTH      = 7,
  parameter int MAX_PKT_LEN = 7,
  parameter int HM_OFFSET   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic [NUM_CH-1:0]             i_ing_valid,
  input  logic [NUM_CH-1:0]             i_ing_header,
  input  logic [NUM_CH*MAX_PKT_LEN-1:0] i_ing_pkt_length,
  input  logic [NUM_CH*32-1:0]          i_ing_dest_ip,
  output logic [NUM_CH-1:0]             o_ing_ready,
  output logic                          o_gsm_wr_en,
  output logic [AWIDTH-1:0]             o_gsm_cell_addr,
  output logic [MWIDTH-1:0]             o_gsm_multicast,
  output logic [$clog2(NUM_CH)-1:0]     o_gsm_ch,
  output logic                          o_gsm_sop,
  input  logic                          i_free_valid,
  input  logic [AWIDTH-1:0]             i_free_addr,
  output logic [AWIDTH:0]               o_avail_cnt,
  output logic                          o_drop,
  output logic                          o_err
`ifdef HW_MALLOC_STATS_EN
  ,
  output logic [15:0]                   o_stat_alloc,
  output logic [15:0]                   o_stat_drop
`endif
);

  localparam int NCELL = 2**AWIDTH;
  localparam int CHW   = $clog2(NUM_CH);
  // Working width wide enough for avail + leftover and for any length value.
  localparam int CW    = (AWIDTH + 2 > MAX_PKT_LEN + 1) ? AWIDTH + 2 : MAX_PKT_LEN + 1;
  localparam logic [AWIDTH:0] FULL = (AWIDTH+1)'(NCELL);

  // Pool and free-list state
  logic [AWIDTH:0]       avail_q, avail_d;
  logic [AWIDTH:0]       init_q, init_d;
  logic [AWIDTH-1:0]     wptr_q, wptr_d;
  logic [AWIDTH-1:0]     rptr_q, rptr_d;
  logic [AWIDTH-1:0]     fifo_mem [NCELL];

  // Arbitration and per-channel packet state
  logic [CHW-1:0]         rr_q, rr_d;
  logic [MAX_PKT_LEN-1:0] rem_q  [NUM_CH];
  logic [MAX_PKT_LEN-1:0] rem_d  [NUM_CH];
  logic [NUM_CH-1:0]      pdrop_q, pdrop_d;
  logic [MWIDTH-1:0]      mvec_q [NUM_CH];
  logic [MWIDTH-1:0]      mvec_d [NUM_CH];

  // Registered outputs
  logic              wr_q, wr_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [MWIDTH-1:0] mc_q, mc_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic              sop_q, sop_d;
  logic              drop_q, drop_d;
  logic              err_q, err_d;

`ifdef HW_MALLOC_STATS_EN
  logic [15:0] st_alloc_q, st_alloc_d;
  logic [15:0] st_drop_q, st_drop_d;
`endif

  // Combinational helpers
  logic                   gnt;
  logic [CHW-1:0]         gch;
  logic [NUM_CH-1:0]      grant_oh;
  logic [MAX_PKT_LEN-1:0] hdr_len;
  logic [MWIDTH-1:0]      hdr_mv;
  logic                   is_hdr;
  logic [MAX_PKT_LEN-1:0] cur_rem;
  logic                   cur_drop;
  logic [MWIDTH-1:0]      cur_mv;
  logic                   free_ok;
  logic                   alloc;
  logic                   sop;
  logic                   drop_ev;
  logic                   err_ev;
  logic [MWIDTH-1:0]      alloc_mv;
  logic [AWIDTH-1:0]      alloc_addr;
  logic [CW-1:0]          leftover;
  logic [CW-1:0]          reserve;
  logic [CW-1:0]          avail_sum;

  // Round-robin search starting at the pointer; first valid channel wins.
  always_comb begin
    gnt      = 1'b0;
    gch      = '0;
    grant_oh = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!gnt && i_ing_valid[(int'(rr_q) + k) % NUM_CH]) begin
        gnt = 1'b1;
        gch = CHW'((int'(rr_q) + k) % NUM_CH);
      end
    end
    if (gnt) grant_oh[gch] = 1'b1;
  end

  assign o_ing_ready = grant_oh;

  // Fields of the granted channel
  always_comb begin
    hdr_len  = i_ing_pkt_length[int'(gch)*MAX_PKT_LEN +: MAX_PKT_LEN];
    hdr_mv   = i_ing_dest_ip[int'(gch)*32 + HM_OFFSET +: MWIDTH];
    is_hdr   = i_ing_header[gch];
    cur_rem  = rem_q[gch];
    cur_drop = pdrop_q[gch];
    cur_mv   = mvec_q[gch];
  end

  // Next-state: header accept/reject, body accounting, pool arithmetic,
  // address source selection and the synchronous clear.
  always_comb begin
    rem_d      = rem_q;
    pdrop_d    = pdrop_q;
    mvec_d     = mvec_q;
    rr_d       = rr_q;
    init_d     = init_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    leftover   = '0;
    reserve    = '0;
    alloc      = 1'b0;
    sop        = 1'b0;
    drop_ev    = 1'b0;
    alloc_mv   = cur_mv;
    alloc_addr = '0;

    free_ok = i_free_valid && (avail_q != FULL);
    err_ev  = i_free_valid && (avail_q == FULL);

    if (gnt) begin
      rr_d = CHW'((int'(gch) + 1) % NUM_CH);
      if (is_hdr) begin
        // Cells still reserved by an unfinished previous packet go back first.
        leftover = CW'(cur_rem);
        if ((hdr_len != '0) && (CW'(hdr_len) <= CW'(avail_q) + CW'(cur_rem)) &&
            (hdr_mv != '0)) begin
          reserve        = CW'(hdr_len);
          rem_d[gch]     = hdr_len - MAX_PKT_LEN'(1);
          pdrop_d[gch]   = 1'b0;
          mvec_d[gch]    = hdr_mv;
          alloc          = 1'b1;
          sop            = 1'b1;
          alloc_mv       = hdr_mv;
        end else begin
          pdrop_d[gch] = 1'b1;
          rem_d[gch]   = '0;
          drop_ev      = 1'b1;
        end
      end else if (!cur_drop) begin
        if (cur_rem != '0) begin
          alloc      = 1'b1;
          rem_d[gch] = cur_rem - MAX_PKT_LEN'(1);
        end else begin
          err_ev = 1'b1;
        end
      end
    end

    // Fresh addresses first, then recycled ones; reservation keeps a source available.
    if (alloc) begin
      if (!init_q[AWIDTH]) begin
        alloc_addr = init_q[AWIDTH-1:0];
        init_d     = init_q + (AWIDTH+1)'(1);
      end else begin
        alloc_addr = fifo_mem[rptr_q];
        rptr_d     = rptr_q + AWIDTH'(1);
      end
    end
    if (free_ok) wptr_d = wptr_q + AWIDTH'(1);

    avail_sum = CW'(avail_q) + CW'(free_ok) + leftover - reserve;
    avail_d   = (AWIDTH+1)'(avail_sum);

    wr_d   = alloc;
    addr_d = alloc ? alloc_addr : '0;
    mc_d   = alloc ? alloc_mv : '0;
    ch_d   = alloc ? gch : '0;
    sop_d  = sop;
    drop_d = drop_ev;
    err_d  = err_ev;

`ifdef HW_MALLOC_STATS_EN
    st_alloc_d = (alloc && st_alloc_q != 16'hFFFF) ? st_alloc_q + 16'd1 : st_alloc_q;
    st_drop_d  = (drop_ev && st_drop_q != 16'hFFFF) ? st_drop_q + 16'd1 : st_drop_q;
`endif

    if (clr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rem_d[c]  = '0;
        mvec_d[c] = '0;
      end
      pdrop_d = '0;
      rr_d    = '0;
      init_d  = '0;
      rptr_d  = '0;
      wptr_d  = '0;
      avail_d = FULL;
      wr_d    = 1'b0;
      addr_d  = '0;
      mc_d    = '0;
      ch_d    = '0;
      sop_d   = 1'b0;
      drop_d  = 1'b0;
      err_d   = 1'b0;
`ifdef HW_MALLOC_STATS_EN
      st_alloc_d = '0;
      st_drop_d  = '0;
`endif
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rem_q[c]  <= '0;
        mvec_q[c] <= '0;
      end
      pdrop_q <= '0;
      rr_q    <= '0;
      init_q  <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      avail_q <= FULL;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      mc_q    <= '0;
      ch_q    <= '0;
      sop_q   <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef HW_MALLOC_STATS_EN
      st_alloc_q <= '0;
      st_drop_q  <= '0;
`endif
    end else begin
      rem_q   <= rem_d;
      mvec_q  <= mvec_d;
      pdrop_q <= pdrop_d;
      rr_q    <= rr_d;
      init_q  <= init_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      avail_q <= avail_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      mc_q    <= mc_d;
      ch_q    <= ch_d;
      sop_q   <= sop_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
`ifdef HW_MALLOC_STATS_EN
      st_alloc_q <= st_alloc_d;
      st_drop_q  <= st_drop_d;
`endif
    end
  end

  // Recycled-address storage; pointers are reset, contents need not be.
  always_ff @(posedge clk) begin
    if (free_ok && !clr) fifo_mem[wptr_q] <= i_free_addr;
  end

  assign o_gsm_wr_en     = wr_q;
  assign o_gsm_cell_addr = addr_q;
  assign o_gsm_multicast = mc_q;
  assign o_gsm_ch        = ch_q;
  assign o_gsm_sop       = sop_q;
  assign o_avail_cnt     = avail_q;
  assign o_drop          = drop_q;
  assign o_err           = err_q;
`ifdef HW_MALLOC_STATS_EN
  assign o_stat_alloc = st_alloc_q;
  assign o_stat_drop  = st_drop_q;
`endif

endmodule

// File: doc/hw_malloc_mc.md
Name: hw_malloc_mc

Overview:
- Multi-channel successor to the single-ingress cell allocator. Serves NUM_CH ingress channels through round-robin arbitration, one cell per cycle.
- Reserves the full packet length on each header, so an accepted packet can never run out of cells mid-packet.
- Owns its free list internally: an init address generator, then a recycled-address FIFO.
- Sits between the ingress parsers and the GSM cell buffer write side.

Parameters:
- NUM_CH, 2, number of ingress channels (≥2).
- MWIDTH, 4, multicast vector width (number of output ports).
- AWIDTH, 7, cell address width; 2**AWIDTH cells in total.
- MAX_PKT_LEN, 7, width of the packet length field (length counted in 16-byte cells).
- HM_OFFSET, 0, bit offset of the multicast vector inside dest_ip.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; same effect as rst.
- i_ing_valid  in  NUM_CH  per-channel cell valid.
- i_ing_header  in  NUM_CH  per-channel header (first cell) flag.
- i_ing_pkt_length  in  NUM_CH*MAX_PKT_LEN  per-channel packet length in cells; sampled on the header.
- i_ing_dest_ip  in  NUM_CH*32  per-channel destination; sampled on the header.
- o_ing_ready  out  NUM_CH  one-hot grant; a cell is consumed when valid & ready.
- o_gsm_wr_en  out  1  allocated-cell write strobe.
- o_gsm_cell_addr  out  AWIDTH  allocated cell address.
- o_gsm_multicast  out  MWIDTH  port vector of the allocated cell.
- o_gsm_ch  out  clog2(NUM_CH)  source channel of the allocated cell.
- o_gsm_sop  out  1  allocated cell is the packet's header cell.
- i_free_valid  in  1  return one cell address to the pool.
- i_free_addr  in  AWIDTH  returned address.
- o_avail_cnt  out  AWIDTH+1  unreserved free cells.
- o_drop  out  1  pulse: header rejected.
- o_err  out  1  pulse: overlong packet cell, or free while pool full.

Behaviour:
- Reset/clear values:
  - avail_cnt = 2**AWIDTH; init_gen = 0; FIFO empty; RR pointer = channel 0.
  - Per-channel remaining = 0, drop = 0, mvec = 0.
  - All outputs 0, except o_avail_cnt = 2**AWIDTH.
  - rst or clr mid-packet discards all state; there is no in-flight completion.
- Arbitration:
  - Combinational round-robin over channels with i_ing_valid=1. The grant appears on o_ing_ready the same cycle.
  - The pointer advances to the granted channel + 1 (mod NUM_CH).
  - At most one grant per cycle. A channel with valid=0 gets ready=0.
- Granted header cell:
  - len = length field, mv = dest_ip[HM_OFFSET+MWIDTH-1:HM_OFFSET].
  - First, any leftover remaining[ch] from the previous packet returns to avail_cnt.
  - Accept when len≠0 & len ≤ (avail_cnt + leftover) & mv≠0. On accept:
    - avail_cnt -= len;
    - remaining[ch] = len-1; drop[ch] = 0; mvec[ch] = mv;
    - allocate one cell with sop=1.
  - Otherwise reject: drop[ch] = 1, remaining[ch] = 0, o_drop = 1 for one cycle (registered), no allocation.
- Granted body cell:
  - drop[ch] = 1: consumed silently, no allocation.
  - remaining[ch] > 0: allocate, remaining -= 1.
  - remaining[ch] = 0 and not dropped: cell discarded, o_err pulse.
- Allocation source:
  - While init_gen < 2**AWIDTH: address = init_gen, then init_gen += 1.
  - After that: pop the FIFO head.
  - Reservation guarantees a source always exists; no bypass path is needed.
- Allocation output:
  - Registered. o_gsm_wr_en, addr, multicast = mvec (or mv on a header), ch and sop are valid exactly 1 cycle after the grant cycle.
- Free path:
  - i_free_valid pushes i_free_addr into a 2**AWIDTH-deep FIFO and increments avail_cnt.
  - Free while avail_cnt = 2**AWIDTH: ignored, o_err pulse.
- Simultaneous events:
  - Free, leftover return and reservation in the same cycle combine arithmetically: avail_next = avail + free + leftover − len_reserved.
  - A FIFO push and pop in the same cycle keep the count unchanged.
- o_avail_cnt is the registered avail_cnt.

Optional Feature:
- Macro: HW_MALLOC_STATS_EN.
- When defined, adds outputs o_stat_alloc[15:0] and o_stat_drop[15:0]:
  - saturating counters of allocated cells and rejected headers;
  - cleared by rst/clr.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Setup: AWIDTH=3, NUM_CH=2. Ch0 sends header len=3 with mv=4'b0001, then 2 body cells → addrs 0,1,2 on cycles grant+1; sop=1 only on addr 0; o_avail_cnt goes 8→5.
- Ch0 and ch1 both valid every cycle → ready alternates 01,10,01; o_gsm_ch follows one cycle later.
- Ch0 len=6 accepted. Ch1 header len=3 while avail=2 → o_drop=1, 3 ch1 cells consumed, no wr_en; avail stays 2.
- Exhaust all 8 addresses, free addr 5 then 2; next packet len=2 → allocated addrs 5, 2, in FIFO order.
- Header len=4 followed by only 1 body cell, then a new header len=1 → leftover 2 returned; avail reflects +2−1 in the same cycle.
- mv=0 header → drop. Free at avail=8 → o_err=1, avail unchanged. With HW_MALLOC_STATS_EN defined, counters match the number of allocated cells and rejected headers.
